// File: rtl/main_buf_packer_if.sv
// Load-stream bundle between the load controller/DMA (master) and the
// main-buffer packer (slave), including the framed output toward the main buffer.
interface main_buf_packer_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int WORD_WIDTH     = 32,
  parameter int NUM_OF_OUTPUTS = 9
);
  logic                         load_valid;
  logic                         load_ready;
  logic signed [DATA_WIDTH-1:0] ifm_in [NUM_OF_OUTPUTS];
  logic signed [DATA_WIDTH-1:0] wgt_in [NUM_OF_OUTPUTS];
  logic signed [DATA_WIDTH-1:0] bias_in;
  logic        [WORD_WIDTH-1:0] out_word;
  logic                         out_valid;
  logic                         frame_start;
  logic                         busy;

  modport master (
    output load_valid, ifm_in, wgt_in, bias_in,
    input  load_ready, out_word, out_valid, frame_start, busy
  );

  modport slave (
    input  load_valid, ifm_in, wgt_in, bias_in,
    output load_ready, out_word, out_valid, frame_start, busy
  );
endinterface

// File: rtl/main_buf_packer.sv
// Serialises one IFM/WGT/BIAS operand set into a gap-free 8-word frame that
// tracks the main buffer's free-running 0..7 slot counter.
module main_buf_packer #(
  parameter int DATA_WIDTH     = 8,
  parameter int WORD_WIDTH     = 32,
  parameter int NUM_OF_OUTPUTS = 9
) (
  input logic              clk,
  input logic              rst,
  main_buf_packer_if.slave bus
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e state_q, state_d;
  logic [2:0] slot_q, slot_d;
  logic pendingFull_q, pendingFull_d;
  logic launch;

  logic signed [DATA_WIDTH-1:0] pendIfm_q [NUM_OF_OUTPUTS];
  logic signed [DATA_WIDTH-1:0] pendIfm_d [NUM_OF_OUTPUTS];
  logic signed [DATA_WIDTH-1:0] pendWgt_q [NUM_OF_OUTPUTS];
  logic signed [DATA_WIDTH-1:0] pendWgt_d [NUM_OF_OUTPUTS];
  logic signed [DATA_WIDTH-1:0] pendBias_q, pendBias_d;

  logic signed [DATA_WIDTH-1:0] actIfm_q [NUM_OF_OUTPUTS];
  logic signed [DATA_WIDTH-1:0] actIfm_d [NUM_OF_OUTPUTS];
  logic signed [DATA_WIDTH-1:0] actWgt_q [NUM_OF_OUTPUTS];
  logic signed [DATA_WIDTH-1:0] actWgt_d [NUM_OF_OUTPUTS];
  logic signed [DATA_WIDTH-1:0] actBias_q, actBias_d;

  logic [WORD_WIDTH-1:0] outWord_q, outWord_d;
  logic outValid_q, outValid_d;
  logic frameStart_q, frameStart_d;

  // A queued set launches either into an idle output or straight after the pad
  // slot, so consecutive frames abut with no bubble.
  always_comb begin
    launch        = pendingFull_q && (state_q == IDLE || slot_q == 3'd7);
    state_d       = state_q;
    slot_d        = slot_q;
    pendingFull_d = pendingFull_q;
    pendIfm_d     = pendIfm_q;
    pendWgt_d     = pendWgt_q;
    pendBias_d    = pendBias_q;
    actIfm_d      = actIfm_q;
    actWgt_d      = actWgt_q;
    actBias_d     = actBias_q;
    outWord_d     = '0;
    outValid_d    = 1'b0;
    frameStart_d  = launch;

    if (launch) begin
      actIfm_d      = pendIfm_q;
      actWgt_d      = pendWgt_q;
      actBias_d     = pendBias_q;
      pendingFull_d = 1'b0;
      state_d       = SEND;
      slot_d        = 3'd0;
    end else if (state_q == SEND) begin
      if (slot_q == 3'd7) begin
        state_d = IDLE;
        slot_d  = 3'd0;
      end else begin
        slot_d = slot_q + 3'd1;
      end
    end

    if (bus.load_valid && !pendingFull_q) begin
      pendIfm_d     = bus.ifm_in;
      pendWgt_d     = bus.wgt_in;
      pendBias_d    = bus.bias_in;
      pendingFull_d = 1'b1;
    end

    // Output word is built from the next active set so it registers together with its slot.
    if (state_d == SEND) begin
      outValid_d = 1'b1;
      case (slot_d)
        3'd0: outWord_d = {actIfm_d[3], actIfm_d[2], actIfm_d[1], actIfm_d[0]};
        3'd1: outWord_d = {actIfm_d[7], actIfm_d[6], actIfm_d[5], actIfm_d[4]};
        3'd2: outWord_d = {{(WORD_WIDTH-DATA_WIDTH){1'b0}}, actIfm_d[8]};
        3'd3: outWord_d = {actWgt_d[3], actWgt_d[2], actWgt_d[1], actWgt_d[0]};
        3'd4: outWord_d = {actWgt_d[7], actWgt_d[6], actWgt_d[5], actWgt_d[4]};
        3'd5: outWord_d = {{(WORD_WIDTH-DATA_WIDTH){1'b0}}, actWgt_d[8]};
        3'd6: outWord_d = {{(WORD_WIDTH-DATA_WIDTH){actBias_d[DATA_WIDTH-1]}}, actBias_d};
        default: outWord_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      slot_q        <= 3'd0;
      pendingFull_q <= 1'b0;
      outWord_q     <= '0;
      outValid_q    <= 1'b0;
      frameStart_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      pendingFull_q <= pendingFull_d;
      outWord_q     <= outWord_d;
      outValid_q    <= outValid_d;
      frameStart_q  <= frameStart_d;
    end
  end

  // Operand storage needs no reset: it is only observed behind the control flags.
  always_ff @(posedge clk) begin
    pendIfm_q  <= pendIfm_d;
    pendWgt_q  <= pendWgt_d;
    pendBias_q <= pendBias_d;
    actIfm_q   <= actIfm_d;
    actWgt_q   <= actWgt_d;
    actBias_q  <= actBias_d;
  end

  assign bus.load_ready  = !pendingFull_q;
  assign bus.busy        = pendingFull_q || (state_q == SEND);
  assign bus.out_word    = outWord_q;
  assign bus.out_valid   = outValid_q;
  assign bus.frame_start = frameStart_q;

endmodule

// File: tb/tb_main_buf_packer.sv
// Directed bench for main_buf_packer: single frame table, back-to-back
// streaming with handshake hold, bias extremes and mid-frame reset.
module tb_main_buf_packer;

  typedef struct {
    logic [31:0] word;
    logic        valid;
    logic        fs;
    logic        ready;
    logic        busy;
  } vec_t;

  typedef struct {
    int ib;
    int is;
    int wb;
    int ws;
    int b;
  } opset_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  main_buf_packer_if #(.DATA_WIDTH(8), .WORD_WIDTH(32), .NUM_OF_OUTPUTS(9)) bus ();

  main_buf_packer #(.DATA_WIDTH(8), .WORD_WIDTH(32), .NUM_OF_OUTPUTS(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Element i of a set is base + step*i, truncated to a byte.
  function automatic logic [31:0] modelWord(opset_t s, int slot);
    logic [7:0] f [9];
    logic [7:0] w [9];
    logic [31:0] r;
    for (int i = 0; i < 9; i++) begin
      f[i] = 8'(s.ib + s.is * i);
      w[i] = 8'(s.wb + s.ws * i);
    end
    case (slot)
      0: r = {f[3], f[2], f[1], f[0]};
      1: r = {f[7], f[6], f[5], f[4]};
      2: r = {24'h0, f[8]};
      3: r = {w[3], w[2], w[1], w[0]};
      4: r = {w[7], w[6], w[5], w[4]};
      5: r = {24'h0, w[8]};
      6: r = 32'(s.b);
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic applyStimulus(input opset_t s, input logic valid);
    for (int i = 0; i < 9; i++) begin
      bus.ifm_in[i] = 8'(s.ib + s.is * i);
      bus.wgt_in[i] = 8'(s.wb + s.ws * i);
    end
    bus.bias_in    = 8'(s.b);
    bus.load_valid = valid;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic runSingle(input string tag, input opset_t s, output logic [31:0] slot6);
    slot6 = 32'h0;
    applyStimulus(s, 1'b1);
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("%s word e%0d", tag, n), bus.out_word,
                  (n <= 8) ? modelWord(s, n - 1) : 32'h0);
      checkOutput($sformatf("%s valid e%0d", tag, n), 32'(bus.out_valid), 32'(n <= 8));
      if (n == 7) slot6 = bus.out_word;
    end
  endtask

  vec_t   tbl [9];
  opset_t setOne, junk, bigBias, minBias, rsA, rsB;
  opset_t b2b [3];
  logic [31:0] w6;
  logic pendExp, sendExp;

  initial begin
    errors = 0;
    checks = 0;

    tbl[0] = '{32'h04030201, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{32'h08070605, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{32'h00000009, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{32'hFCFDFEFF, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{32'hF8F9FAFB, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{32'h000000F7, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{32'hFFFFFFFB, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};

    setOne  = '{1, 1, -1, -1, -5};
    junk    = '{-100, 3, 77, 5, 55};
    bigBias = '{5, 7, -20, 3, 127};
    minBias = '{-9, -2, 40, -4, -128};
    b2b[0]  = '{10, 1, -3, -2, 100};
    b2b[1]  = '{30, 1, -23, -2, 50};
    b2b[2]  = '{50, 1, -43, -2, 0};
    rsA     = '{60, 2, -60, 3, 11};
    rsB     = '{-70, 1, 70, -1, -11};

    // Reset state
    rst = 1'b1;
    applyStimulus(junk, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_word", bus.out_word, 32'h0);
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("reset frame_start", 32'(bus.frame_start), 32'h0);
    checkOutput("reset busy", 32'(bus.busy), 32'h0);
    checkOutput("reset load_ready", 32'(bus.load_ready), 32'h1);
    rst = 1'b0;

    // Single set from idle, table-driven
    applyStimulus(setOne, 1'b1);
    @(posedge clk); #1;
    checkOutput("single accept ready", 32'(bus.load_ready), 32'h0);
    checkOutput("single accept busy", 32'(bus.busy), 32'h1);
    checkOutput("single accept valid", 32'(bus.out_valid), 32'h0);
    applyStimulus(junk, 1'b0);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("single word e%0d", i + 1), bus.out_word, tbl[i].word);
      checkOutput($sformatf("single valid e%0d", i + 1), 32'(bus.out_valid), 32'(tbl[i].valid));
      checkOutput($sformatf("single fs e%0d", i + 1), 32'(bus.frame_start), 32'(tbl[i].fs));
      checkOutput($sformatf("single ready e%0d", i + 1), 32'(bus.load_ready), 32'(tbl[i].ready));
      checkOutput($sformatf("single busy e%0d", i + 1), 32'(bus.busy), 32'(tbl[i].busy));
    end

    // Back-to-back with valid held; junk is shown whenever ready is low
    for (int e = 0; e <= 25; e++) begin
      if (e == 0)       applyStimulus(b2b[0], 1'b1);
      else if (e == 2)  applyStimulus(b2b[1], 1'b1);
      else if (e == 10) applyStimulus(b2b[2], 1'b1);
      else if (e < 10)  applyStimulus(junk, 1'b1);
      else              applyStimulus(junk, 1'b0);
      @(posedge clk); #1;
      pendExp = (e == 0) || (e >= 2 && e <= 8) || (e >= 10 && e <= 16);
      sendExp = (e >= 1 && e <= 24);
      checkOutput($sformatf("b2b word e%0d", e), bus.out_word,
                  sendExp ? modelWord(b2b[(e - 1) / 8], (e - 1) % 8) : 32'h0);
      checkOutput($sformatf("b2b valid e%0d", e), 32'(bus.out_valid), 32'(sendExp));
      checkOutput($sformatf("b2b fs e%0d", e), 32'(bus.frame_start),
                  32'(e == 1 || e == 9 || e == 17));
      checkOutput($sformatf("b2b ready e%0d", e), 32'(bus.load_ready), 32'(!pendExp));
      checkOutput($sformatf("b2b busy e%0d", e), 32'(bus.busy), 32'(pendExp || sendExp));
    end

    // Bias sign-extension extremes
    runSingle("bias127", bigBias, w6);
    checkOutput("bias127 slot6", w6, 32'h0000007F);
    runSingle("biasm128", minBias, w6);
    checkOutput("biasm128 slot6", w6, 32'hFFFFFF80);

    // Reset at slot 4 with a second set pending
    applyStimulus(rsA, 1'b1);
    @(posedge clk); #1;
    applyStimulus(rsB, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst pre slot4 word", bus.out_word, modelWord(rsA, 4));
    checkOutput("rst pre pending ready", 32'(bus.load_ready), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("rst out_word", bus.out_word, 32'h0);
    checkOutput("rst load_ready", 32'(bus.load_ready), 32'h1);
    checkOutput("rst busy", 32'(bus.busy), 32'h0);
    checkOutput("rst frame_start", 32'(bus.frame_start), 32'h0);
    rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("post-rst valid c%0d", n), 32'(bus.out_valid), 32'h0);
      checkOutput($sformatf("post-rst busy c%0d", n), 32'(bus.busy), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/main_buf_packer.md
# main_buf_packer

Transmit-side packer for the main buffer load stream. Accepts one operand set (nine signed 8-bit IFM values, nine signed 8-bit weights, one signed 8-bit bias) over a valid/ready handshake. Serialises each set into an 8-word, 32-bit frame: IFM in slots 0-2, WGT in slots 3-5, BIAS in slot 6, pad in slot 7. It sits between the load controller/DMA and the main buffer, whose free-running 0..7 slot counter it must feed contiguously with no gaps inside a frame.

## Interface
- DATA_WIDTH, 8, element width; fixed, other values unsupported
- WORD_WIDTH, 32, stream word width; must equal 4*DATA_WIDTH
- NUM_OF_OUTPUTS, 9, elements per IFM/WGT window; fixed at 9 (3 words each)
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- load_valid  in  1  operand set on ifm_in/wgt_in/bias_in is valid
- load_ready  out  1  packer can accept a set this cycle
- ifm_in  in  9 x DATA_WIDTH signed  IFM window elements [0..8]
- wgt_in  in  9 x DATA_WIDTH signed  weight elements [0..8]
- bias_in  in  DATA_WIDTH signed  bias
- out_word  out  WORD_WIDTH  stream word to main buffer (registered)
- out_valid  out  1  out_word carries a frame slot (registered)
- frame_start  out  1  high with slot 0 of every frame; main buffer start_signal
- busy  out  1  frame in flight or set pending

## Operation
- Two storage stages: pending (1 set + full flag) and active (1 set + 3-bit slot counter).
- load_ready = !pending_full. Accept on rising edge with load_valid && load_ready; the set is copied into pending and pending_full is set.
- States: IDLE (no frame in flight), SEND (slot counter 0..7 presented on out_word).
- Launch condition: pending_full && (IDLE || presented slot == 7). On a launch edge, pending moves to active, pending_full clears, slot = 0 is presented, frame_start = 1, state becomes SEND.
- In SEND, slot increments each edge. After slot 7 with no launch, the state becomes IDLE, out_valid = 0, and out_word = 0.
- Packing (byte k of a word = bits 8k+7:8k):
  - slot0 = {ifm[3],ifm[2],ifm[1],ifm[0]}
  - slot1 = {ifm[7..4]}
  - slot2 = {24'h0, ifm[8]}
  - slots 3-5: same packing with wgt
  - slot6 = bias_in sign-extended to 32 bits
  - slot7 = 32'h0
- out_valid = 1 for all 8 slots, including the pad slot. A frame is never interrupted or stalled once launched; there is no downstream backpressure.
- Inputs are sampled only at accept; later changes on ifm_in/wgt_in/bias_in do not affect queued or active frames.
- busy = pending_full || state == SEND.

## Timing
- Reset values: out_word = 0, out_valid = 0, frame_start = 0, busy = 0, load_ready = 1, pending_full = 0, state = IDLE, slot = 0.
- Latency: set accepted at edge k (from IDLE) gives slot 0 at edge k+1 and slot 7 at edge k+8.
- Back-to-back: if pending is full when slot 7 is presented at edge j, the next slot 0 (frame_start = 1) follows at edge j+1. The output stays continuous at 1 word/cycle.
- load_ready returns high the cycle after a launch. Sustained throughput is one set per 8 cycles with no bubbles.
- No simultaneous accept and launch into pending: load_ready is low whenever pending is full.
- frame_start is a 1-cycle pulse; it is never high on slots 1-7.
- rst asserted mid-frame: at the next edge all outputs take their reset values and pending/active contents are discarded. No partial frame resumes after reset.
- rst has priority over accept and launch in the same cycle.

## Test plan
- Single set, idle start. Stimulus: ifm = 1..9, wgt = -1..-9, bias = -5, accepted at edge 0. Required: edges 1-8 give 32'h04030201, 32'h08070605, 32'h00000009, 32'hFCFDFEFF, 32'hF8F9FAFB, 32'h000000F7, 32'hFFFFFFFB, 32'h00000000. out_valid is high on edges 1-8 and low at edge 9. frame_start is high on edge 1 only.
- Back-to-back. Stimulus: three sets with load_valid held high. Required: 24 consecutive valid words, frame_start at edges 1, 9 and 17, no idle cycle between frames. load_ready is low while pending is full.
- Handshake hold. Stimulus: load_valid high while pending is full, then input data changed before load_ready rises. Required: the value present at the accepting edge is transmitted; nothing is lost or duplicated.
- Positive bias. Stimulus: bias = 8'sd127. Required: slot6 = 32'h0000007F. With bias = -128, required: slot6 = 32'hFFFFFF80.
- Reset mid-frame. Stimulus: rst pulsed at slot 4 with a second set pending. Required: the next edge gives out_valid = 0, out_word = 0, load_ready = 1 and busy = 0. The pending set is never transmitted.
